// File: rtl/regfile_dump_pkg.sv
// Shared types and default sizing for the register file dump reader.
// Imported by the dump interface and the dump reader itself.
package regfile_dump_pkg;

  localparam int DEF_BITSIZE = 64;
  localparam int DEF_REGSIZE = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Register file read port plus the outgoing valid/ready dump stream.
// master = dump reader, slave = register file / stream consumer side.
interface regfile_dump_reader_if
  import regfile_dump_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE,
  parameter int REGSIZE = DEF_REGSIZE
);
  localparam int IW = $clog2(REGSIZE);

  logic [IW-1:0]      rd_sel;
  logic [BITSIZE-1:0] rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [BITSIZE-1:0] out_data;
  logic [IW-1:0]      out_index;
  logic               out_last;
  logic               out_is_csum;

  modport master (
    output rd_sel, out_valid, out_data, out_index, out_last, out_is_csum,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_sel, out_valid, out_data, out_index, out_last, out_is_csum,
    output rd_data, out_ready
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks every register through the async read port and streams it out tagged with its index.
// Build option: define DUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE,
  parameter int REGSIZE = DEF_REGSIZE
)
(
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic abort_i,
  output logic busy_o,
  output logic done_o,
  regfile_dump_reader_if.master dump_if
);

  localparam int IW = $clog2(REGSIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(REGSIZE - 1);

  dump_state_e        state_q;
  logic [IW-1:0]      idx_q;
  logic [IW-1:0]      idx_d;
  logic [BITSIZE-1:0] out_data_q;
  logic [IW-1:0]      out_index_q;
  logic               out_last_q;
  logic               out_is_csum_q;
  logic               out_valid;

`ifdef DUMP_CHECKSUM_EN
  logic [BITSIZE-1:0] acc_q;
  logic [BITSIZE-1:0] acc_d;

  assign acc_d = acc_q ^ dump_if.rd_data;
`endif

  assign idx_d     = idx_q + 1'b1;
  assign out_valid = (state_q == SEND) || (state_q == CSUM);

  // rd_sel is the index register itself, so the read data is valid throughout FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      out_last_q    <= 1'b0;
      out_is_csum_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      acc_q         <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= FETCH;
            idx_q   <= '0;
`ifdef DUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
          end
        end
        FETCH: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else begin
            out_data_q    <= dump_if.rd_data;
            out_index_q   <= idx_q;
            out_is_csum_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            out_last_q    <= 1'b0;
            acc_q         <= acc_d;
`else
            out_last_q    <= (idx_q == LAST_IDX);
`endif
            state_q       <= SEND;
          end
        end
        SEND: begin
          // abort wins over a handshake landing on the same edge
          if (abort_i) begin
            state_q <= IDLE;
          end else if (dump_if.out_ready) begin
            if (idx_q == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
              state_q       <= CSUM;
              out_data_q    <= acc_q;
              out_index_q   <= '0;
              out_last_q    <= 1'b1;
              out_is_csum_q <= 1'b1;
`else
              state_q       <= DONE;
`endif
            end else begin
              idx_q   <= idx_d;
              state_q <= FETCH;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        CSUM: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else if (dump_if.out_ready) begin
            state_q <= DONE;
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dump_if.rd_sel      = idx_q;
  assign dump_if.out_valid   = out_valid;
  assign dump_if.out_data    = out_data_q;
  assign dump_if.out_index   = out_index_q;
  assign dump_if.out_last    = out_last_q;
  assign dump_if.out_is_csum = out_is_csum_q;

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule
